// File: rtl/clk_div_prog.sv
// Programmable divider: CLK_OUT pattern and CE_OUT strobe, with bit-slip phase shift and lock flag.
// Outputs lag internal state by one CLK_IN cycle; no backpressure, requests captured every cycle.
module clk_div_prog #(
  parameter int DIV_WIDTH   = 4,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 CLK_IN,
  input  logic                 SRESET,
  input  logic                 ENABLE,
  input  logic [DIV_WIDTH-1:0] DIV_VAL,
  input  logic                 DIV_LOAD,
  input  logic                 BIT_SLIP,
  output logic                 CLK_OUT,
  output logic                 CE_OUT,
  output logic [DIV_WIDTH-1:0] DIV_ACTIVE,
  output logic                 SLIP_DONE,
  output logic                 LOCKED
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] n_act;
  logic [DIV_WIDTH-1:0] n_pend;
  logic                 run;
  logic                 pend_div;
  logic                 pend_slip;
  logic                 slip_d;
  logic                 hold;
  logic                 ce_seen;
  logic                 lock;

  logic [DIV_WIDTH:0]   half;
  logic                 last;
  logic                 ce_now;
  logic                 clk_now;
  logic                 slip_rise;
  logic [DIV_WIDTH-1:0] div_clamped;

  always_comb begin
    half        = ({1'b0, n_act} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
    last        = (cnt == (n_act - ONE));
    ce_now      = run && (cnt == '0) && !hold;
    clk_now     = run && ({1'b0, cnt} < half);
    slip_rise   = BIT_SLIP && !slip_d;
    div_clamped = (DIV_VAL < TWO) ? TWO : DIV_VAL;
  end

  always_ff @(posedge CLK_IN) begin
    if (SRESET) begin
      cnt       <= '0;
      run       <= 1'b0;
      n_act     <= DEF_DIV;
      n_pend    <= DEF_DIV;
      pend_div  <= 1'b0;
      pend_slip <= 1'b0;
      slip_d    <= 1'b0;
      hold      <= 1'b0;
      ce_seen   <= 1'b0;
      lock      <= 1'b0;
      CLK_OUT   <= 1'b0;
      CE_OUT    <= 1'b0;
      SLIP_DONE <= 1'b0;
    end else begin
      CLK_OUT   <= clk_now;
      CE_OUT    <= ce_now;
      SLIP_DONE <= run && hold;
      slip_d    <= BIT_SLIP;

      // Exclusive with the clear below: applying a slip requires pend_slip already set.
      if (slip_rise && !pend_slip)
        pend_slip <= 1'b1;

      if (!run) begin
        cnt  <= '0;
        hold <= 1'b0;
        if (ENABLE)
          run <= 1'b1;
      end else if (!ENABLE) begin
        run     <= 1'b0;
        cnt     <= '0;
        hold    <= 1'b0;
        lock    <= 1'b0;
        ce_seen <= 1'b0;
      end else begin
        if (ce_now) begin
          if (ce_seen)
            lock <= 1'b1;
          else
            ce_seen <= 1'b1;
        end
        if (last && pend_slip && !hold) begin
          hold      <= 1'b1;
          pend_slip <= 1'b0;
        end else if (last) begin
          cnt  <= '0;
          hold <= 1'b0;
          if (pend_div) begin
            n_act    <= n_pend;
            pend_div <= 1'b0;
            if (n_pend != n_act) begin
              lock    <= 1'b0;
              ce_seen <= 1'b0;
            end
          end
        end else begin
          cnt <= cnt + ONE;
        end
      end

      // Placed last so a load on the wrap edge re-arms pend_div for the next wrap.
      if (DIV_LOAD) begin
        n_pend   <= div_clamped;
        pend_div <= 1'b1;
      end
    end
  end

  assign DIV_ACTIVE = n_act;
  assign LOCKED     = lock;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed segments push per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       sreset;
  logic       enable;
  logic [3:0] div_val;
  logic       div_load;
  logic       bit_slip;
  logic       clk_out;
  logic       ce_out;
  logic [3:0] div_active;
  logic       slip_done;
  logic       locked;

  typedef struct {
    logic       ck;
    logic       ce;
    logic       sd;
    logic       lk;
    logic [3:0] da;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   row     = 0;

  always #5 clk = ~clk;

  clk_div_prog #(.DIV_WIDTH(4), .DEFAULT_DIV(4)) dut (
    .CLK_IN     (clk),
    .SRESET     (sreset),
    .ENABLE     (enable),
    .DIV_VAL    (div_val),
    .DIV_LOAD   (div_load),
    .BIT_SLIP   (bit_slip),
    .CLK_OUT    (clk_out),
    .CE_OUT     (ce_out),
    .DIV_ACTIVE (div_active),
    .SLIP_DONE  (slip_done),
    .LOCKED     (locked)
  );

  task automatic chk(input string name, input int r, input int act, input int req);
    n_total++;
    if (act == req)
      n_pass++;
    else
      $display("FAIL %s row %0d: got %0d, expected %0d", name, r, act, req);
  endtask

  // Each character is the expected output for one cycle; inputs are held for
  // the segment and take effect from the following cycle.
  task automatic seg(input logic en, input logic [3:0] dv, input logic ld,
                     input logic bs, input logic rst,
                     input string ck, input string ce, input string sd,
                     input string lk, input logic [3:0] da);
    exp_t e;
    for (int i = 0; i < ck.len(); i++) begin
      @(posedge clk);
      #1;
      enable   = en;
      div_val  = dv;
      div_load = ld;
      bit_slip = bs;
      sreset   = rst;
      e.ck = (ck[i] == "1");
      e.ce = (ce[i] == "1");
      e.sd = (i < sd.len()) ? (sd[i] == "1") : 1'b0;
      e.lk = (lk[i] == "1");
      e.da = da;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("clk_out",    row, int'(clk_out),    int'(e.ck));
        chk("ce_out",     row, int'(ce_out),     int'(e.ce));
        chk("slip_done",  row, int'(slip_done),  int'(e.sd));
        chk("locked",     row, int'(locked),     int'(e.lk));
        chk("div_active", row, int'(div_active), int'(e.da));
        row++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    sreset   = 1'b1;
    enable   = 1'b0;
    div_val  = 4'd4;
    div_load = 1'b0;
    bit_slip = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state, then enable at default divide-by-4
    seg(0, 4, 0, 0, 1, "0", "0", "", "0", 4);
    seg(1, 4, 0, 0, 0, "00110011001100", "00100010001000", "", "00000011111111", 4);

    // Load 5 mid-period: current period finishes, lock drops for one period
    seg(1, 5, 0, 0, 0, "1", "1", "", "1", 4);
    seg(1, 5, 1, 0, 0, "1", "0", "", "1", 4);
    seg(1, 5, 0, 0, 0, "0", "0", "", "1", 4);
    seg(1, 5, 0, 0, 0, "0111001110011100", "0100001000010000", "", "0000001111111111", 5);

    // Divisor 1 clamps to 2
    seg(1, 1, 1, 0, 0, "1", "1", "", "1", 5);
    seg(1, 1, 0, 0, 0, "110", "000", "", "111", 5);
    seg(1, 1, 0, 0, 0, "01010101", "01010101", "", "00011111", 2);

    // Back to 4
    seg(1, 4, 1, 0, 0, "0", "0", "", "1", 2);
    seg(1, 4, 0, 0, 0, "1", "1", "", "1", 2);
    seg(1, 4, 0, 0, 0, "011001100", "010001000", "", "000001111", 4);

    // Slip with a second rising edge inside the pending window
    seg(1, 4, 0, 1, 0, "1", "1", "", "1", 4);
    seg(1, 4, 0, 0, 0, "1", "0", "", "1", 4);
    seg(1, 4, 0, 1, 0, "0", "0", "", "1", 4);
    seg(1, 4, 0, 0, 0, "0011001100", "0010001000", "0100000000", "1111111111", 4);

    // Slip and divisor 6 pending at the same boundary
    seg(1, 6, 1, 1, 0, "1", "1", "", "1", 4);
    seg(1, 6, 0, 0, 0, "100", "000", "", "111", 4);
    seg(1, 6, 0, 0, 0, "0111000111000", "0100000100000", "1000000000000", "0000000111111", 6);

    // Enable dropped mid-period, then re-enabled
    seg(1, 6, 0, 0, 0, "111", "100", "", "111", 6);
    seg(0, 6, 0, 0, 0, "000", "000", "", "100", 6);
    seg(1, 6, 0, 0, 0, "001110001", "001000001", "", "000000001", 6);

    // Reset with slip and divisor 3 pending: both discarded
    seg(1, 3, 1, 1, 0, "1", "0", "", "1", 6);
    seg(1, 3, 0, 0, 1, "1", "0", "", "1", 6);
    seg(1, 3, 0, 0, 0, "00110011001100", "00100010001000", "00000000000000", "00000011111111", 4);

    repeat (3) @(negedge clk);
    chk("queue_drained", row, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable, phase-adjustable clock divider. Successor to the fixed divide-by-4 divider primitive wrapper.
- Derives a divided clock-pattern output (CLK_OUT) and a one-cycle clock-enable strobe (CE_OUT) from CLK_IN.
- Adds a programmable divisor, a bit-slip phase shift of one input cycle, an enable input, a synchronous reset and a lock indication.
- Feeds ADC deserializer framing and slow-domain clock enables in the digitizer fabric. All logic is in the CLK_IN domain.

Parameters:
DIV_WIDTH, 4, width of divisor bus; legal divisors 2..2^DIV_WIDTH-1
DEFAULT_DIV, 4, divisor active after reset; must be within 2..2^DIV_WIDTH-1

Ports:
CLK_IN  in  1  input clock, sole clock of block
SRESET  in  1  synchronous reset, active-high
ENABLE  in  1  run enable; low holds divider idle
DIV_VAL  in  DIV_WIDTH  requested divisor
DIV_LOAD  in  1  one-cycle request to capture DIV_VAL
BIT_SLIP  in  1  level input; rising edge requests a +1 input-cycle phase shift
CLK_OUT  out  1  divided clock pattern, registered
CE_OUT  out  1  one CLK_IN-cycle strobe at start of each output period, registered
DIV_ACTIVE  out  DIV_WIDTH  divisor currently in use
SLIP_DONE  out  1  one-cycle pulse when a slip is applied
LOCKED  out  1  high once the output period is stable

Behaviour:
- State: cnt (DIV_WIDTH bits), run, N_act, N_pend, pend_div, pend_slip, slip_d (BIT_SLIP delayed), hold, lock.
- All outputs are driven directly from flops, so there is no combinational glitch path.
- Output decode, valid at edge t from state at t:
  - H = ceil(N_act/2).
  - CLK_OUT = run and cnt < H.
  - CE_OUT = run and cnt == 0 and not hold.
- Reset (SRESET=1 at an edge) has priority over everything:
  - cnt=0, run=0, N_act=DEFAULT_DIV.
  - Pending flags, hold, slip_d and lock are cleared.
  - Outputs: CLK_OUT=0, CE_OUT=0, SLIP_DONE=0, LOCKED=0, DIV_ACTIVE=DEFAULT_DIV.
- Divisor clamp: DIV_VAL < 2 is captured as 2.
- IDLE (run=0):
  - ENABLE=0 keeps cnt=0 and run=0; pending requests are kept.
  - ENABLE=1 sets run=1, cnt=0. The first CE_OUT/CLK_OUT high appears 1 cycle after ENABLE is first sampled high.
- RUN: cnt increments each cycle and wraps from N_act-1 to 0.
  - ENABLE sampled 0 returns to IDLE at that edge: cnt=0, lock=0, outputs low next cycle.
- DIV_LOAD=1 at an edge sets N_pend=clamped DIV_VAL and pend_div=1. A later DIV_LOAD overwrites N_pend (last wins).
- Divisor change is applied only at the wrap from N_act-1 to 0:
  - If pend_div was set before that edge, N_act becomes N_pend and pend_div is cleared.
  - A DIV_LOAD on the wrap edge itself is applied at the following wrap.
  - No truncated periods occur.
- Slip request: BIT_SLIP=1 and slip_d=0 sets pend_slip. A request while pend_slip=1 is dropped.
- Slip application: at cnt==N_act-1 with pend_slip=1, cnt stays at N_act-1 for one extra cycle (hold=1).
  - pend_slip is cleared and SLIP_DONE pulses in that held cycle.
  - Net effect: one output period of N_act+1 cycles (low phase stretched) and a phase shift of +1 input cycle.
- Slip and divisor change at the same boundary: the slip hold occurs first, then the divisor is applied at the wrap that follows the hold.
- LOCKED:
  - Set at the second CE_OUT after entering RUN.
  - Cleared on reset, on IDLE, and for one full period whenever N_act changes (re-set at the second CE_OUT under the new divisor).
  - A slip does not clear LOCKED.
- DIV_ACTIVE = N_act.
- Odd divisors: high phase is (N+1)/2 cycles, low phase (N-1)/2.

Test Plan:
- Reset then ENABLE=1 with DEFAULT_DIV=4:
  - CLK_OUT pattern 1,1,0,0 repeating from the cycle after ENABLE.
  - CE_OUT every 4 cycles.
  - LOCKED high at the 2nd CE_OUT.
  - DIV_ACTIVE=4.
- DIV_VAL=5 with a DIV_LOAD mid-period:
  - Current 4-cycle period completes intact, then CLK_OUT 1,1,1,0,0 repeating.
  - LOCKED drops for one period, then returns.
  - DIV_LOAD with DIV_VAL=1 yields period 2 (pattern 1,0).
- BIT_SLIP rising edge during run at N=4:
  - One period of 5 cycles (pattern 1,1,0,0,0).
  - SLIP_DONE pulses once.
  - Subsequent CE_OUT shifted +1 cycle.
  - A second edge inside the same pending window is ignored (only one stretched period).
- Slip and DIV_LOAD=6 pending at the same boundary:
  - Hold cycle first, then a 6-cycle period 1,1,1,0,0,0.
  - Exactly one SLIP_DONE.
- ENABLE dropped mid-period:
  - Outputs and LOCKED go to 0 the next cycle.
  - Re-enable restarts at cnt=0 with a CE_OUT one cycle after ENABLE is sampled high.
- SRESET asserted mid-period with pending slip and divisor:
  - All outputs 0, DIV_ACTIVE=DEFAULT_DIV.
  - Pending requests are discarded (no SLIP_DONE and no divisor change after release).
